// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding (8-bit, same width as the controller
// FSM) and the ACK/NACK bit levels as seen on SDA.
package i2c_pkg;

  typedef enum logic [7:0] {
    IDLE     = 8'h00,
    ADDR     = 8'h01,
    ACK_ADDR = 8'h02,
    DATA     = 8'h03,
    ACK_DATA = 8'h04,
    IGNORE   = 8'h05
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with SCL edge and START/STOP condition detection.
// Reusable by any I2C target that oversamples the bus on its system clock.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sda_s
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_p;
  logic                   r_sda_p;
  logic                   w_scl_s;
  logic                   w_sda_s;

  // Reset to 1 (idle bus) so releasing reset never fabricates an edge or condition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_p    <= 1'b1;
      r_sda_p    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_p    <= w_scl_s;
      r_sda_p    <= w_sda_s;
    end
  end

  assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

  assign o_scl_rise = w_scl_s & ~r_scl_p;
  assign o_scl_fall = ~w_scl_s & r_scl_p;
  assign o_start    = w_scl_s & r_scl_p & r_sda_p & ~w_sda_s;
  assign o_stop     = w_scl_s & r_scl_p & ~r_sda_p & w_sda_s;
  assign o_sda_s    = w_sda_s;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: matches a 7-bit address, ACKs, and hands each received
// data byte to local logic through a valid/ready handshake.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       stop_det
);

  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_sda_s;

  i2c_state_e r_state,    w_state_nx;
  logic [3:0] r_cnt,      w_cnt_nx;
  logic [7:0] r_shift,    w_shift_nx;
  logic [7:0] r_rx_data,  w_rx_data_nx;
  logic       r_rx_valid, w_rx_valid_nx;
  logic       r_sda_oe,   w_sda_oe_nx;
  logic       r_busy,     w_busy_nx;
  logic       r_stop_det, w_stop_det_nx;
  logic       r_ack_bit,  w_ack_bit_nx;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_scl     (scl_in),
    .i_sda     (sda_in),
    .o_scl_rise(w_scl_rise),
    .o_scl_fall(w_scl_fall),
    .o_start   (w_start),
    .o_stop    (w_stop),
    .o_sda_s   (w_sda_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_shift    <= 8'd0;
      r_rx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_stop_det <= 1'b0;
      r_ack_bit  <= I2C_NACK;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_shift    <= w_shift_nx;
      r_rx_data  <= w_rx_data_nx;
      r_rx_valid <= w_rx_valid_nx;
      r_sda_oe   <= w_sda_oe_nx;
      r_busy     <= w_busy_nx;
      r_stop_det <= w_stop_det_nx;
      r_ack_bit  <= w_ack_bit_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_shift_nx    = r_shift;
    w_rx_data_nx  = r_rx_data;
    w_rx_valid_nx = 1'b0;
    w_sda_oe_nx   = r_sda_oe;
    w_busy_nx     = r_busy;
    w_stop_det_nx = 1'b0;
    w_ack_bit_nx  = r_ack_bit;

    // Bus conditions pre-empt bit handling in every state; STOP wins over START.
    if (w_stop) begin
      w_state_nx    = IDLE;
      w_sda_oe_nx   = 1'b0;
      w_busy_nx     = 1'b0;
      w_stop_det_nx = 1'b1;
    end else if (w_start) begin
      w_state_nx  = ADDR;
      w_cnt_nx    = 4'd0;
      w_shift_nx  = 8'd0;
      w_sda_oe_nx = 1'b0;
      w_busy_nx   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_sda_oe_nx = 1'b0;
        end
        ADDR: begin
          if (r_cnt != 4'd8 && w_scl_rise) begin
            w_shift_nx = {r_shift[6:0], w_sda_s};
            w_cnt_nx   = r_cnt + 4'd1;
          end else if (r_cnt == 4'd8 && w_scl_fall) begin
            if (r_shift[7:1] == TARGET_ADDR && r_shift[0] == 1'b0) begin
              w_state_nx  = ACK_ADDR;
              w_sda_oe_nx = 1'b1;
              w_busy_nx   = 1'b1;
            end else begin
              w_state_nx  = IGNORE;
              w_sda_oe_nx = 1'b0;
            end
          end
        end
        ACK_ADDR: begin
          if (w_scl_fall) begin
            w_sda_oe_nx = 1'b0;
            w_cnt_nx    = 4'd0;
            w_state_nx  = DATA;
          end
        end
        DATA: begin
          if (r_cnt != 4'd8 && w_scl_rise) begin
            w_shift_nx = {r_shift[6:0], w_sda_s};
            w_cnt_nx   = r_cnt + 4'd1;
            // The 8th bit completes the byte: present it and decide ACK/NACK now.
            if (r_cnt == 4'd7) begin
              w_rx_data_nx  = {r_shift[6:0], w_sda_s};
              w_rx_valid_nx = rx_ready;
              w_ack_bit_nx  = rx_ready ? I2C_ACK : I2C_NACK;
            end
          end else if (r_cnt == 4'd8 && w_scl_fall) begin
            w_state_nx  = ACK_DATA;
            w_sda_oe_nx = (r_ack_bit == I2C_ACK);
          end
        end
        ACK_DATA: begin
          if (w_scl_fall) begin
            w_sda_oe_nx = 1'b0;
            if (r_ack_bit == I2C_ACK) begin
              w_cnt_nx   = 4'd0;
              w_state_nx = DATA;
            end else begin
              w_state_nx = IGNORE;
            end
          end
        end
        IGNORE: begin
          w_sda_oe_nx = 1'b0;
        end
        default: begin
          w_state_nx  = IDLE;
          w_sda_oe_nx = 1'b0;
          w_busy_nx   = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe   = r_sda_oe;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;
  assign stop_det = r_stop_det;

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- Write-only I2C target (slave) receiver; the far end of the team's I2C controller transmitter.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches the 7-bit address, ACKs by pulling SDA low, and delivers each received data byte to local logic with a valid/ready handshake.
- Sits between the board-level open-drain pad (tri-state buffer outside this block) and the consumer register file.

Parameters:
- TARGET_ADDR, 7'h42, 7-bit address this target responds to.
- SYNC_STAGES, 2, flops in the SCL/SDA input synchronizers (minimum 2).

Ports:
- clk  input  1  system clock; at least 8x the SCL frequency.
- rst  input  1  reset, asynchronous, active-low.
- scl_in  input  1  raw SCL from pad, asynchronous.
- sda_in  input  1  raw SDA from pad, asynchronous.
- sda_oe  output  1  1 = drive SDA low (ACK); 0 = release.
- rx_data  output  8  last received data byte, MSB first on the wire.
- rx_valid  output  1  one-cycle pulse; rx_data is valid in that cycle.
- rx_ready  input  1  consumer can accept a byte; sampled at byte completion.
- busy  output  1  high from address match until STOP or repeated START.
- stop_det  output  1  one-cycle pulse on any detected STOP.

Behaviour:
- Reset (rst low, asynchronous): state = IDLE, bit counter = 0, shift register = 0, rx_data = 0, sda_oe = 0, rx_valid = 0, busy = 0, stop_det = 0. Synchronizer flops reset to 1, the idle bus level.
- Synchronizers:
  - scl_s and sda_s are SYNC_STAGES-deep synchronized copies; scl_p and sda_p are their values one cycle earlier.
  - scl_rise = scl_s & ~scl_p.
  - scl_fall = ~scl_s & scl_p.
- Bus conditions:
  - START = scl_s & scl_p & sda_p & ~sda_s.
  - STOP = scl_s & scl_p & ~sda_p & sda_s.
- Priority: STOP > START > bit events, evaluated in every state.
- States: IDLE, ADDR, ACK_ADDR, DATA, ACK_DATA, IGNORE.
  - Any state, on START: go to ADDR, clear bit counter and shift register, sda_oe = 0, busy = 0. This covers repeated START.
  - Any state, on STOP: go to IDLE, sda_oe = 0, busy = 0; pulse stop_det the following cycle.
  - IDLE: wait for START.
  - ADDR:
    - On each scl_rise, shift sda_s into shift[0]; counter += 1.
    - After the 8th bit, on the next scl_fall: if shift[7:1] == TARGET_ADDR and shift[0] == 0 (write), go to ACK_ADDR, set sda_oe = 1 and busy = 1.
    - Otherwise (address mismatch, or R/W = 1) go to IGNORE with sda_oe = 0.
  - ACK_ADDR: on the next scl_fall, sda_oe = 0, clear counter, go to DATA.
  - DATA:
    - Shift 8 bits on scl_rise, as in ADDR.
    - In the cycle after the 8th scl_rise: rx_data = shift, and pulse rx_valid if rx_ready = 1; record ack_pending = rx_ready.
    - On the next scl_fall, go to ACK_DATA with sda_oe = ack_pending. If the byte was refused, it is dropped and the transfer is NACKed.
  - ACK_DATA:
    - On the next scl_fall, sda_oe = 0.
    - If the byte was ACKed, clear counter and go to DATA.
    - If it was NACKed, go to IGNORE.
  - IGNORE: sda_oe = 0; wait for START or STOP.
- Latency: sda_oe changes exactly 1 clk after the clk in which scl_fall is detected (a registered output).
- sda_oe is never asserted while scl_s is high, except when the ACK bit is held through its SCL high phase.
- START and STOP detection is unaffected by the target's own ACK: sda_oe is released before the controller generates STOP.
- rx_valid is never asserted for address bytes or outside DATA.
- Reset asserted mid-byte: all state is lost immediately; the bus is released within 0 cycles (async). After reset deasserts, the block stays in IDLE until a fresh START.

Decomposition:
- Package i2c_pkg: the state encoding constants (shared with the controller FSM encoding width, 8 bits) and I2C_ACK = 1'b0 / I2C_NACK = 1'b1.
- Sub-module i2c_bus_sync: synchronizers plus edge and START/STOP detection, outputs scl_rise, scl_fall, start, stop, sda_s. It is reusable by a future target transmitter.

Test Plan:
- Write to 0x42 with byte 0xA5, rx_ready = 1:
  - ACK on the address 9th clock and on the data 9th clock.
  - One rx_valid pulse with rx_data = 0xA5.
  - stop_det pulse after STOP; busy returns to 0.
- Address 0x43 write with byte 0x11:
  - No ACK at all; sda_oe stays 0 throughout; rx_valid is never asserted; busy stays 0.
- Address 0x42 with R/W = 1:
  - NACK; block sits in IGNORE until STOP; no rx_valid.
- Write 0x42, then bytes 0x01, 0x02, with rx_ready dropped before the second byte:
  - First byte ACKed with rx_valid.
  - Second byte NACKed with no rx_valid; block ignores until STOP.
- Write 0x42, byte 0x3C, then repeated START, then address 0x42, byte 0xC3:
  - Both bytes delivered in order.
  - No stop_det until the final STOP.
- Reset asserted during the 4th data bit:
  - sda_oe = 0 and all outputs at reset values immediately.
  - A subsequent full write of 0x7E is received correctly.
